// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, press/release debounce, hex key code.
// Define KEYPAD_SHIFT_ACC_EN to build the 8-digit shift accumulator behind data_out.

module keypad_scanner #(
    parameter int SCAN_DIV  = 100000,
    parameter int DEB_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    input  logic        clr,
    output logic [3:0]  col_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [31:0] data_out
);

    localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEBW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
    localparam logic [DEBW-1:0] DEB_LAST = DEBW'(DEB_TICKS - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      row_meta_q, row_meta_d;
    logic [3:0]      row_sync_q, row_sync_d;
    logic [DIVW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [DEBW-1:0] deb_cnt_q, deb_cnt_d;
    logic [DEBW-1:0] deb_inc;
    logic            key_valid_q, key_valid_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            tick, any_low, row_still_low, accept;
    logic [1:0]      low_row;
    logic [3:0]      new_code;

    always_comb begin
        row_meta_d    = row_in;
        row_sync_d    = row_meta_q;
        tick          = (div_cnt_q == DIV_LAST);
        div_cnt_d     = tick ? '0 : div_cnt_q + DIVW'(1);
        any_low       = (row_sync_q != 4'hF);
        row_still_low = ~row_sync_q[row_idx_q];
        deb_inc       = deb_cnt_q + DEBW'(1);
        // Lowest-index row wins when several rows are pulled low together
        if (!row_sync_q[0])      low_row = 2'd0;
        else if (!row_sync_q[1]) low_row = 2'd1;
        else if (!row_sync_q[2]) low_row = 2'd2;
        else                     low_row = 2'd3;
    end

    always_comb begin
        new_code = 4'h0;
        case ({row_idx_q, col_idx_q})
            4'd0:  new_code = 4'h1;
            4'd1:  new_code = 4'h2;
            4'd2:  new_code = 4'h3;
            4'd3:  new_code = 4'hA;
            4'd4:  new_code = 4'h4;
            4'd5:  new_code = 4'h5;
            4'd6:  new_code = 4'h6;
            4'd7:  new_code = 4'hB;
            4'd8:  new_code = 4'h7;
            4'd9:  new_code = 4'h8;
            4'd10: new_code = 4'h9;
            4'd11: new_code = 4'hC;
            4'd12: new_code = 4'hE;
            4'd13: new_code = 4'h0;
            4'd14: new_code = 4'hF;
            4'd15: new_code = 4'hD;
            default: new_code = 4'h0;
        endcase
        key_valid_d = accept;
        key_code_d  = accept ? new_code : key_code_q;
    end

    // The column index stays put outside SCAN, so it doubles as the latched column
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        deb_cnt_d = deb_cnt_q;
        accept    = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        row_idx_d = low_row;
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_still_low) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                PRESSED: begin
                    if (!any_low) begin
                        deb_cnt_d = '0;
                        state_d   = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!any_low) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            state_d   = SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_cnt_q   <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            deb_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            div_cnt_q   <= div_cnt_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            deb_cnt_q   <= deb_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    always_comb begin
        col_out   = ~(4'b0001 << col_idx_q);
        key_held  = (state_q == PRESSED) || (state_q == RELEASE);
        key_valid = key_valid_q;
        key_code  = key_code_q;
    end

`ifdef KEYPAD_SHIFT_ACC_EN
    logic [31:0] acc_q, acc_d;

    // clr beats a simultaneous accept: the display is blanked, key_code still updates
    always_comb begin
        acc_d = acc_q;
        if (clr)         acc_d = '0;
        else if (accept) acc_d = {acc_q[27:0], new_code};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign data_out = acc_q;
`else
    logic clr_unused;

    assign clr_unused = clr;
    assign data_out   = {28'b0, key_code_q};
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random key activity, checked
// against a tick-level keypad/debounce reference model (honours KEYPAD_SHIFT_ACC_EN).

module tb_keypad_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_TICKS = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr   = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [31:0] data_out;
    logic [15:0] key_down = '0;

    int checks      = 0;
    int passes      = 0;
    int pulse_count = 0;

    int          m_phase   = 0;
    int          m_col     = 0;
    int          m_row     = 0;
    int          m_run     = 0;
    int          m_accepts = 0;
    logic        m_valid   = 1'b0;
    logic [3:0]  m_code    = 4'h0;
    logic [31:0] m_data    = '0;
    logic [3:0]  code_map [16];

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .clr(clr),
        .col_out(col_out), .key_valid(key_valid), .key_code(key_code),
        .key_held(key_held), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column while that column is driven low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(negedge clk) if (key_valid === 1'b1) pulse_count <= pulse_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    function automatic logic [3:0] col_mask(input int col);
        logic [3:0] m = 4'h0;
        for (int r = 0; r < 4; r++) m[r] = key_down[r*4+col];
        return m;
    endfunction

    function automatic bit will_accept();
        logic [3:0] m = col_mask(m_col);
        return (m_phase == 1) && (m_run == DEB_TICKS - 1) && m[m_row];
    endfunction

    // Phases: 0 scanning, 1 counting a press, 2 held, 3 counting a release; m_run = stable samples seen
    task automatic modelTick();
        logic [3:0] m = col_mask(m_col);
        m_valid = 1'b0;
        case (m_phase)
            0: if (m != 4'h0) begin
                   for (int r = 3; r >= 0; r--) if (m[r]) m_row = r;
                   m_run = 1; m_phase = 1;
               end else m_col = (m_col + 1) % 4;
            1: if (m[m_row]) begin
                   m_run++;
                   if (m_run == DEB_TICKS) begin m_valid = 1'b1; m_phase = 2; end
               end else begin m_phase = 0; m_col = (m_col + 1) % 4; end
            2: if (m == 4'h0) begin m_run = 1; m_phase = 3; end
            default: if (m == 4'h0) begin
                   m_run++;
                   if (m_run == DEB_TICKS) begin m_phase = 0; m_col = (m_col + 1) % 4; end
               end else m_run = 1;
        endcase
        if (m_valid) begin
            m_code = code_map[m_row*4 + m_col];
            m_accepts++;
        end
`ifdef KEYPAD_SHIFT_ACC_EN
        if (m_valid) m_data = {m_data[27:0], m_code};
        if (clr) m_data = '0;
`else
        m_data = {28'b0, m_code};
`endif
    endtask

    // One scan-tick window: the tick edge is the last of SCAN_DIV clocks
    task automatic applyStimulus();
        logic [3:0] exp_col;
        repeat (SCAN_DIV) @(posedge clk);
        #1;
        modelTick();
        exp_col = 4'hF;
        exp_col[m_col] = 1'b0;
        checkOutput("col_out", 32'(col_out), 32'(exp_col));
        checkOutput("key_valid", 32'(key_valid), 32'(m_valid));
        checkOutput("key_code", 32'(key_code), 32'(m_code));
        checkOutput("key_held", 32'(key_held), 32'(m_phase >= 2));
        checkOutput("data_out", data_out, m_data);
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        clr   = 1'b0;
        #1;
        checkOutput({tag, "_col"}, 32'(col_out), 32'hE);
        checkOutput({tag, "_valid"}, 32'(key_valid), 32'h0);
        checkOutput({tag, "_code"}, 32'(key_code), 32'h0);
        checkOutput({tag, "_held"}, 32'(key_held), 32'h0);
        checkOutput({tag, "_data"}, data_out, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_phase = 0; m_col = 0; m_run = 0;
        m_code  = 4'h0; m_data = '0; m_valid = 1'b0;
    endtask

    initial begin
        int p0;
        int seen;
        int k;
        logic [31:0] exp_seq;
        logic [31:0] exp_clr;

        code_map = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                     4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
`ifdef KEYPAD_SHIFT_ACC_EN
        exp_seq = 32'h23456789;
        exp_clr = 32'h0;
`else
        exp_seq = 32'h9;
        exp_clr = 32'hD;
`endif
        #2;
        doReset("rst0");

        // Key '6' (row 1, col 2) held across the scan
        p0 = pulse_count;
        key_down[6] = 1'b1;
        repeat (8) applyStimulus();
        key_down = '0;
        repeat (5) applyStimulus();
        checkOutput("s6_pulses", 32'(pulse_count - p0), 32'd1);
        checkOutput("s6_code", 32'(key_code), 32'h6);
        checkOutput("s6_data", data_out, 32'h6);

        // Keys 1..9 in order, each cleanly released
        doReset("rst1");
        p0 = pulse_count;
        for (int d = 1; d <= 9; d++) begin
            key_down[((d-1)/3)*4 + (d-1)%3] = 1'b1;
            repeat (8) applyStimulus();
            key_down = '0;
            repeat (6) applyStimulus();
        end
        checkOutput("seq_pulses", 32'(pulse_count - p0), 32'd9);
        checkOutput("seq_data", data_out, exp_seq);

        // Single-tick bounce on the column being scanned
        doReset("rst2");
        p0 = pulse_count;
        key_down[2*4 + m_col] = 1'b1;
        applyStimulus();
        key_down = '0;
        applyStimulus();
        checkOutput("bounce_col", 32'(col_out), 32'hD);
        checkOutput("bounce_held", 32'(key_held), 32'h0);
        repeat (3) applyStimulus();
        checkOutput("bounce_pulses", 32'(pulse_count - p0), 32'd0);

        // Long hold with a short release glitch yields a single press
        doReset("rst3");
        p0 = pulse_count;
        key_down[5] = 1'b1;
        repeat (20) applyStimulus();
        key_down = '0;
        applyStimulus();
        key_down[5] = 1'b1;
        repeat (2) applyStimulus();
        key_down = '0;
        repeat (4) applyStimulus();
        checkOutput("hold_pulses", 32'(pulse_count - p0), 32'd1);

        // clr lands on the very tick that accepts 'D'
        seen = 0;
        key_down[15] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            clr = will_accept();
            applyStimulus();
            if (m_valid) begin
                seen++;
                checkOutput("clr_data", data_out, exp_clr);
                checkOutput("clr_code", 32'(key_code), 32'hD);
            end
        end
        clr = 1'b0;
        key_down = '0;
        repeat (5) applyStimulus();
        checkOutput("clr_seen", 32'(seen), 32'd1);

        // Reset while debouncing, key kept down: press must be re-debounced from scratch
        doReset("rst4");
        key_down[8] = 1'b1;
        repeat (2) applyStimulus();
        #3;
        doReset("rst_mid");
        repeat (6) applyStimulus();
        key_down = '0;
        repeat (5) applyStimulus();

        // Random key activity, including multi-key columns and stray clr
        doReset("rst5");
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 99) < 15) begin
                k = $urandom_range(0, 15);
                key_down[k] = ~key_down[k];
            end
            if ($countones(key_down) > 2) key_down = '0;
            clr = ($urandom_range(0, 24) == 0);
            applyStimulus();
        end
        clr = 1'b0;
        key_down = '0;
        repeat (8) applyStimulus();
        checkOutput("pulse_total", 32'(pulse_count), 32'(m_accepts));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per scan tick (1 kHz at 100 MHz).
REQ-002 SHALL have parameter DEB_TICKS, default 10, meaning consecutive stable ticks required to accept a press or a release.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_n  input  1  reset; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 SHALL have port row_in  input  4  keypad rows, active-low, externally pulled up.
REQ-006 SHALL have port clr  input  1  synchronous clear of the data_out accumulator.
REQ-007 SHALL have port col_out  output  4  column drive, one-hot active-low.
REQ-008 SHALL have port key_valid  output  1  one-clk pulse when a debounced press is accepted.
REQ-009 SHALL have port key_code  output  4  hex code of the last accepted key.
REQ-010 SHALL have port key_held  output  1  high while the FSM is in PRESSED or RELEASE.
REQ-011 SHALL have port data_out  output  32  accumulated hex digits (8 nibbles), for the 7-segment display.

Function
REQ-012 SHALL synchronise row_in through two flip-flops; all row decisions SHALL use the synchronised value.
REQ-013 SHALL generate a one-clk tick every SCAN_DIV cycles from a counter that wraps from SCAN_DIV-1 to 0; the counter SHALL free-run in every state.
REQ-014 SHALL drive col_out low on exactly one column (col 0 = 4'b1110); the column SHALL change only on a tick.
REQ-015 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-016 SCAN, on tick: if any synced row is low -> latch the lowest-index low row and the current column, deb_cnt=0, go DEBOUNCE; otherwise advance the column 0->1->2->3->0.
REQ-017 DEBOUNCE, on tick (column held): if the latched row is still low, deb_cnt++; when deb_cnt reaches DEB_TICKS-1 -> go PRESSED and assert key_valid for exactly 1 clk.
REQ-017a DEBOUNCE, on tick: if the latched row is high -> go SCAN and advance the column.
REQ-018 PRESSED, on tick: if all synced rows are high -> deb_cnt=0, go RELEASE; otherwise stay; no repeat key_valid is generated.
REQ-019 RELEASE, on tick: if all rows are high, deb_cnt++; at DEB_TICKS-1 -> go SCAN and advance the column.
REQ-019a RELEASE, on tick: if any row is low -> deb_cnt=0, stay in RELEASE.
REQ-020 Code map (row,col): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
REQ-021 key_code SHALL update in the same clk that key_valid asserts and hold until the next accepted press.
REQ-022 On key_valid, data_out SHALL become {data_out[27:0], key_code}; the top nibble is discarded.
REQ-023 clr SHALL zero data_out on the next clk edge; if clr coincides with key_valid, data_out SHALL be 0 and key_code SHALL still update.
REQ-024 With multiple rows low in one column, only the lowest-index row SHALL be accepted; other columns are ignored until the FSM returns to SCAN.

Reset
REQ-025 SHALL reset asynchronously on rst_n low to: state SCAN, col_out=4'b1110, key_valid=0, key_code=0, key_held=0, data_out=0, all counters 0, synchronisers all-ones.
REQ-026 Reset mid-press SHALL discard the press; after release of reset the key SHALL need a full DEB_TICKS debounce.

Configuration
REQ-027 Macro KEYPAD_SHIFT_ACC_EN: when defined, data_out SHALL behave per REQ-022/023.
REQ-027a When KEYPAD_SHIFT_ACC_EN is undefined, data_out SHALL equal {28'b0, key_code}, clr SHALL have no effect, and no accumulator register SHALL be built.

Verification
REQ-028 Scenario: SCAN_DIV=4, DEB_TICKS=3; hold row1 low while col2 is driven for 5 ticks -> one key_valid pulse, key_code=4'h6, data_out=32'h00000006.
REQ-029 Scenario: press 1,2,3,...,9 in sequence, each with a clean release -> data_out=32'h23456789 (shift mode).
REQ-030 Scenario: row bounces low for 1 tick then high (DEB_TICKS=3) -> no key_valid, column advances, FSM returns to SCAN.
REQ-031 Scenario: hold the key for 20 ticks, then release for 1 tick, re-press, then release for 3 ticks -> exactly one key_valid.
REQ-032 Scenario: clr asserted in the same clk as key_valid for key 'D' -> data_out=0, key_code=4'hD.
REQ-033 Scenario: rst_n asserted during DEBOUNCE -> all outputs at reset values within the same cycle, col_out=4'b1110.
